cpu_cycle_sequencer: RTL and testbench
======================================

Name: cpu_cycle_sequencer

Overview:
Top-level cycle controller for the multi-cycle LEGv8 core. It fetches each instruction over a req/ack instruction-memory port and holds it in the instruction register feeding the control unit. It then steps the control unit's multi-cycle micro-state, stalling on data-memory handshakes, and issues a one-cycle commit strobe per micro-step that gates all architectural writes. It also provides halt/resume, a retired-instruction counter and a sticky watchdog error.

Parameters:
ADDR_W, 64, PC / instruction-memory address width
INSTR_W, 32, instruction width
MAX_STEPS, 4, maximum micro-steps per instruction (exec_next nonzero at most MAX_STEPS-1 times)
TIMEOUT, 255, maximum wait cycles for any ack before error

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
pc  in  ADDR_W  current PC from the PC register
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address, held stable while imem_req=1
imem_ack  in  1  fetch complete, imem_rdata valid this cycle
imem_rdata  in  INSTR_W  fetched instruction
instruction  out  INSTR_W  instruction register, to control unit
exec_next  in  2  control unit next micro-state (0 = instruction done)
dmem_req  in  1  current micro-step accesses data memory (from controlword)
dmem_ack  in  1  data memory access complete
cw_commit  out  1  micro-step commit; enables regfile/PC/status/control-unit-state writes
halt_req  in  1  request halt at next instruction boundary
resume  in  1  leave HALT
halted  out  1  in HALT state
error  out  1  sticky watchdog/step-limit error
instr_count  out  32  retired instructions, wraps

Behaviour:
- States: FETCH, EXEC, HALT, ERROR. Reset → FETCH. All outputs 0 on reset; instruction=0; instr_count=0; internal wait and step counters=0.
- FETCH:
  - imem_req=1 and imem_addr=pc. The address is captured on the first FETCH cycle and held until ack, even if pc changes.
  - On imem_ack: instruction<=imem_rdata, step=0, wait=0, next state EXEC.
  - imem_req deasserts the cycle after ack. Zero-wait ack, meaning ack in the first req cycle, is legal: 1 cycle fetch.
- EXEC:
  - If dmem_req=1 and dmem_ack=0: stall. cw_commit=0, wait++.
  - Otherwise: cw_commit=1 for exactly this cycle and wait=0.
  - If exec_next≠0: stay in EXEC, step++.
  - If exec_next=0: instr_count++ and the instruction retires. Next state is HALT if halt_req=1 in this cycle, else FETCH.
- Minimum latency: 2 cycles per single-step instruction (FETCH+EXEC) with zero-wait memories.
- Step limit: if a commit occurs with exec_next≠0 while step=MAX_STEPS-1 → ERROR with no commit, and instr_count is not incremented.
- Watchdog: wait reaching TIMEOUT in FETCH or in an EXEC stall → ERROR next cycle. An ack arriving in that same cycle wins: normal progress, no error.
- HALT: halted=1, imem_req=0, cw_commit=0. resume=1 → FETCH next cycle. halt_req outside an instruction boundary is ignored (level-sampled only at retire).
- ERROR: error=1, halted=0, imem_req=0, cw_commit=0. The state is left only by reset.
- Reset mid-fetch or mid-stall: req drops the next cycle, and no commit or count occurs for the aborted instruction.
- instr_count wraps 0xFFFFFFFF→0.
- imem_ack outside FETCH and dmem_ack without dmem_req are ignored.

Decomposition:
- Shared control package holds:
  - state encoding constants SEQ_FETCH=0, SEQ_EXEC=1, SEQ_HALT=2, SEQ_ERROR=3
  - the exec_next "done" value 2'b00
- One natural sub-module, seq_watchdog: a wait counter with clear and increment inputs, parameter TIMEOUT, and an expired output. Instantiated once.

Test Plan:
- Zero-wait memories, 3 single-step instrs, pc=0,4,8 → imem_addr 0,4,8. cw_commit high in cycles 2,4,6 after reset release; instr_count=3.
- imem_ack delayed 5 cycles, pc changed to 0x40 mid-wait → imem_addr stays 0x0 and req stays high 6 cycles. instruction=rdata at ack.
- Multi-step instr, exec_next 1,2,0 with dmem_req on step 2 and dmem_ack after 3 cycles → 3 commits total, 3 stall cycles with cw_commit=0, instr_count+1.
- halt_req asserted mid-instruction held to retire → HALT after retire, halted=1, no imem_req. resume pulse → FETCH the next cycle.
- imem_ack never arrives → error=1 after 255 wait cycles, stays set. Reset then restores FETCH with instr_count=0.
- exec_next stuck at 1 → ERROR on the 4th commit attempt. Exactly 3 commits observed and instr_count unchanged.

Source files
------------

// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared definitions for the LEGv8 multi-cycle sequencer: state encoding,
// the control unit's "instruction done" micro-state value and a width helper.
package cpu_cycle_sequencer_pkg;

    // Sequencer states; encodings are fixed so state dumps stay readable.
    typedef enum logic [1:0] {
        SEQ_FETCH = 2'd0,
        SEQ_EXEC  = 2'd1,
        SEQ_HALT  = 2'd2,
        SEQ_ERROR = 2'd3
    } seq_state_t;

    // exec_next value meaning the current instruction has finished.
    localparam logic [1:0] EXEC_DONE = 2'b00;

    // Bits needed to hold the values 0..n (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-cycle counter for the sequencer. Counts cycles spent waiting on an
// acknowledge and flags when the count has reached TIMEOUT.
module seq_watchdog
    import cpu_cycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic expired
);

    localparam int unsigned W = cnt_width(TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    // Wait counter: clear wins over increment, saturates at the limit.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (incr && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Cycle controller for the multi-cycle LEGv8 core. Fetches an instruction
// over the req/ack instruction port, then walks the control unit's
// micro-steps, stalling on data-memory handshakes and strobing cw_commit once
// per completed micro-step. Provides halt/resume at instruction boundaries,
// a retired-instruction counter and a sticky watchdog/step-limit error.
module cpu_cycle_sequencer
    import cpu_cycle_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned INSTR_W   = 32,
    parameter int unsigned MAX_STEPS = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    input  logic [1:0]         exec_next,
    input  logic               dmem_req,
    input  logic               dmem_ack,
    output logic               cw_commit,
    input  logic               halt_req,
    input  logic               resume,
    output logic               halted,
    output logic               error,
    output logic [31:0]        instr_count
);

    localparam int unsigned       STEP_W    = cnt_width(MAX_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [STEP_W-1:0]  step_q;
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        count_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               hold_q;

    logic commit;
    logic load_instr;
    logic step_clr;
    logic step_inc;
    logic count_inc;
    logic wd_clear;
    logic wd_incr;
    logic wd_expired;
    logic run;

    // Outputs are forced quiet while reset is asserted so an aborted fetch
    // or stall never shows a request or a commit.
    assign run = ~reset;

    seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .incr   (wd_incr),
        .expired(wd_expired)
    );

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d    = state_q;
        commit     = 1'b0;
        load_instr = 1'b0;
        step_clr   = 1'b0;
        step_inc   = 1'b0;
        count_inc  = 1'b0;
        wd_clear   = 1'b1;
        wd_incr    = 1'b0;

        case (state_q)
            SEQ_FETCH: begin
                // An ack in the expiry cycle still wins over the watchdog.
                if (imem_ack) begin
                    load_instr = 1'b1;
                    step_clr   = 1'b1;
                    state_d    = SEQ_EXEC;
                end else if (wd_expired) begin
                    state_d = SEQ_ERROR;
                end else begin
                    wd_clear = 1'b0;
                    wd_incr  = 1'b1;
                end
            end

            SEQ_EXEC: begin
                if (dmem_req && !dmem_ack) begin
                    if (wd_expired) begin
                        state_d = SEQ_ERROR;
                    end else begin
                        wd_clear = 1'b0;
                        wd_incr  = 1'b1;
                    end
                end else if (exec_next != EXEC_DONE) begin
                    // A further step beyond the last legal one is a runaway
                    // control sequence: suppress the commit and trap.
                    if (step_q == STEP_LAST) begin
                        state_d = SEQ_ERROR;
                    end else begin
                        commit   = 1'b1;
                        step_inc = 1'b1;
                    end
                end else begin
                    commit    = 1'b1;
                    count_inc = 1'b1;
                    state_d   = halt_req ? SEQ_HALT : SEQ_FETCH;
                end
            end

            SEQ_HALT: begin
                if (resume) begin
                    state_d = SEQ_FETCH;
                end
            end

            SEQ_ERROR: begin
                state_d = SEQ_ERROR;
            end

            default: begin
                state_d = SEQ_ERROR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SEQ_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch address capture: latch pc on the first FETCH cycle and hold it
    // for as long as the fetch keeps waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= 1'b0;
            addr_q <= '0;
        end else begin
            hold_q <= (state_q == SEQ_FETCH) && (state_d == SEQ_FETCH);
            if ((state_q == SEQ_FETCH) && !hold_q) begin
                addr_q <= pc;
            end
        end
    end

    // Instruction register, loaded on fetch acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q <= '0;
        end else if (load_instr) begin
            instr_q <= imem_rdata;
        end
    end

    // Micro-step counter within the current instruction.
    always_ff @(posedge clock) begin
        if (reset || step_clr) begin
            step_q <= '0;
        end else if (step_inc) begin
            step_q <= step_q + 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_inc) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign imem_req    = run && (state_q == SEQ_FETCH);
    assign imem_addr   = imem_req ? (hold_q ? addr_q : pc) : '0;
    assign cw_commit   = run && commit;
    assign halted      = run && (state_q == SEQ_HALT);
    assign error       = run && (state_q == SEQ_ERROR);
    assign instruction = instr_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Scoreboard bench for cpu_cycle_sequencer. The driver plays an open-loop
// schedule of instructions (fetch latency, micro-steps, data stalls, halts)
// and predicts, from cycle arithmetic, when each fetch completes, each commit
// fires, and when halt/error begin. A separate monitor turns DUT outputs into
// observed events and compares them against the expected queue.
module tb_cpu_cycle_sequencer;

    localparam int ADDR_W    = 64;
    localparam int INSTR_W   = 32;
    localparam int MAX_STEPS = 4;
    localparam int TIMEOUT   = 255;

    logic               clock;
    logic               reset;
    logic [ADDR_W-1:0]  pc;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instruction;
    logic [1:0]         exec_next;
    logic               dmem_req;
    logic               dmem_ack;
    logic               cw_commit;
    logic               halt_req;
    logic               resume;
    logic               halted;
    logic               error;
    logic [31:0]        instr_count;

    cpu_cycle_sequencer #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .MAX_STEPS(MAX_STEPS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .exec_next  (exec_next),
        .dmem_req   (dmem_req),
        .dmem_ack   (dmem_ack),
        .cw_commit  (cw_commit),
        .halt_req   (halt_req),
        .resume     (resume),
        .halted     (halted),
        .error      (error),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum int {EV_FETCH, EV_COMMIT, EV_HALT, EV_ERROR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          cyc;
        logic [63:0] data;
    } ev_t;
    typedef struct {
        int          cyc;
        int          tag;
        logic [67:0] data;
    } snap_t;

    ev_t   evq[$];
    snap_t snq[$];

    int  total = 0;
    int  bad   = 0;
    bit  done  = 1'b0;

    logic [31:0] model_count = '0;
    logic [31:0] model_instr = '0;
    int          step_dly[MAX_STEPS];

    // ---------------- driver side ----------------

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.cyc  = cyc;
        e.data = d;
        evq.push_back(e);
    endtask

    task automatic expect_snap(input int tag, input logic req, input logic com,
                               input logic hlt, input logic err,
                               input logic [31:0] cnt, input logic [31:0] ins);
        snap_t s;
        s.cyc  = cyc;
        s.tag  = tag;
        s.data = {req, com, hlt, err, cnt, ins};
        snq.push_back(s);
    endtask

    // Every input the current state should ignore gets random junk.
    task automatic scramble();
        pc         = {$urandom, $urandom};
        imem_ack   = ($urandom_range(0, 1) == 1);
        imem_rdata = $urandom;
        exec_next  = 2'($urandom_range(0, 3));
        dmem_req   = ($urandom_range(0, 1) == 1);
        dmem_ack   = ($urandom_range(0, 1) == 1);
        halt_req   = ($urandom_range(0, 1) == 1);
        resume     = ($urandom_range(0, 1) == 1);
    endtask

    task automatic do_reset(input bit check_entry);
        scramble();
        reset = 1'b1;
        if (check_entry) expect_snap(1, 1'b0, 1'b0, 1'b0, 1'b0, model_count, model_instr);
        tick();
        scramble();
        expect_snap(2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        scramble();
        tick();
        reset       = 1'b0;
        model_count = '0;
        model_instr = '0;
    endtask

    // Fetch with fw wait cycles before the ack; address is pc of cycle 0.
    task automatic do_fetch(input int fw);
        logic [63:0] addr;
        logic [31:0] word;
        word = $urandom;
        addr = '0;
        for (int k = 0; k <= fw; k++) begin
            scramble();
            imem_ack = (k == fw);
            if (k == 0) addr = pc;
            if (k == fw) begin
                imem_rdata = word;
                expect_ev(EV_FETCH, addr);
            end
            tick();
        end
        model_instr = word;
    endtask

    // One micro-step; d<0 means no data access, else d stall cycles first.
    task automatic do_step(input int d, input logic [1:0] nxt, input bit commits,
                           input logic hreq);
        if (d < 0) begin
            scramble();
            dmem_req  = 1'b0;
            exec_next = nxt;
            halt_req  = hreq;
            if (commits) expect_ev(EV_COMMIT, {model_count, model_instr});
            tick();
        end else begin
            for (int j = 0; j <= d; j++) begin
                scramble();
                dmem_req  = 1'b1;
                dmem_ack  = (j == d);
                exec_next = nxt;
                if (j == d) begin
                    halt_req = hreq;
                    if (commits) expect_ev(EV_COMMIT, {model_count, model_instr});
                end
                tick();
            end
        end
    endtask

    task automatic run_instr(input int fw, input int ns, input bit do_halt, input int hcyc);
        logic [1:0] nxt;
        do_fetch(fw);
        for (int s = 0; s < ns; s++) begin
            nxt = (s == ns - 1) ? 2'd0 : 2'($urandom_range(1, 3));
            do_step(step_dly[s], nxt, 1'b1,
                    (s == ns - 1) ? do_halt : ($urandom_range(0, 1) == 1));
        end
        model_count = model_count + 32'd1;
        if (do_halt) begin
            expect_ev(EV_HALT, 64'd0);
            for (int h = 0; h <= hcyc; h++) begin
                scramble();
                resume = (h == hcyc);
                if (h == 0) expect_snap(3, 1'b0, 1'b0, 1'b1, 1'b0, model_count, model_instr);
                tick();
            end
        end
    endtask

    task automatic clear_dly();
        for (int s = 0; s < MAX_STEPS; s++) step_dly[s] = -1;
    endtask

    task automatic hold_error(input int n);
        for (int k = 0; k < n; k++) begin
            scramble();
            expect_snap(4, 1'b0, 1'b0, 1'b0, 1'b1, model_count, model_instr);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        scramble();
        clear_dly();
        do_reset(1'b0);

        // Three zero-wait single-step instructions back to back.
        for (int i = 0; i < 3; i++) run_instr(0, 1, 1'b0, 0);
        // Slow fetch with pc wandering during the wait.
        run_instr(5, 1, 1'b0, 0);
        // Three steps, the middle one stalls three cycles on data memory.
        step_dly[1] = 3;
        run_instr(0, 3, 1'b0, 0);
        clear_dly();
        // Halt at retire, sit halted, then resume.
        run_instr(1, 2, 1'b1, 3);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            for (int s = 0; s < MAX_STEPS; s++)
                step_dly[s] = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 4));
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(1, MAX_STEPS)),
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end
        clear_dly();

        // Acks landing exactly in the expiry cycle still make progress.
        run_instr(TIMEOUT, 1, 1'b0, 0);
        step_dly[0] = TIMEOUT;
        run_instr(0, MAX_STEPS, 1'b0, 0);
        clear_dly();

        // Runaway control sequence: exec_next stuck nonzero.
        do_fetch(0);
        for (int s = 0; s < MAX_STEPS - 1; s++) do_step(-1, 2'd1, 1'b1, 1'b0);
        do_step(-1, 2'd1, 1'b0, 1'b0);
        expect_ev(EV_ERROR, 64'd0);
        hold_error(4);
        do_reset(1'b1);

        // Fetch acknowledge never arrives.
        for (int k = 0; k <= TIMEOUT; k++) begin
            scramble();
            imem_ack = 1'b0;
            tick();
        end
        expect_ev(EV_ERROR, 64'd0);
        hold_error(3);
        do_reset(1'b1);

        // Data acknowledge never arrives.
        do_fetch(0);
        for (int k = 0; k <= TIMEOUT; k++) begin
            scramble();
            dmem_req = 1'b1;
            dmem_ack = 1'b0;
            tick();
        end
        expect_ev(EV_ERROR, 64'd0);
        hold_error(2);
        do_reset(1'b1);

        // Reset in the middle of a data stall aborts the instruction.
        do_fetch(2);
        for (int k = 0; k < 3; k++) begin
            scramble();
            dmem_req = 1'b1;
            dmem_ack = 1'b0;
            tick();
        end
        do_reset(1'b1);
        run_instr(0, 2, 1'b0, 0);

        scramble();
        imem_ack = 1'b0;
        tick();
        expect_snap(5, 1'b1, 1'b0, 1'b0, 1'b0, model_count, model_instr);
        scramble();
        imem_ack = 1'b0;
        tick();
        done = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- monitor side ----------------

    function automatic string kname(input ev_kind_t k);
        case (k)
            EV_FETCH:  return "fetch";
            EV_COMMIT: return "commit";
            EV_HALT:   return "halt";
            default:   return "error";
        endcase
    endfunction

    task automatic observe(input ev_kind_t k, input logic [63:0] d);
        ev_t e;
        total++;
        if (evq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s @%0d: got data=%h, required no event", kname(k), cyc, d);
        end else begin
            e = evq.pop_front();
            if (e.kind != k || e.cyc != cyc || e.data != d)
                bad++;
            if (e.kind != k || e.cyc != cyc || e.data != d)
                $display("FAIL event_%s @%0d: got %s data=%h, required %s @%0d data=%h",
                         kname(e.kind), cyc, kname(k), d, kname(e.kind), e.cyc, e.data);
        end
    endtask

    logic halted_q = 1'b0;
    logic error_q  = 1'b0;

    always @(negedge clock) begin
        snap_t       s;
        ev_t         e;
        logic [67:0] obs;

        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            e = evq.pop_front();
            total++;
            bad++;
            $display("FAIL missed_%s: required @%0d data=%h, got nothing by @%0d",
                     kname(e.kind), e.cyc, e.data, cyc);
        end

        obs = {imem_req, cw_commit, halted, error, instr_count, instruction};
        while (snq.size() > 0 && snq[0].cyc <= cyc) begin
            s = snq.pop_front();
            total++;
            if (s.cyc != cyc || obs != s.data) begin
                bad++;
                $display("FAIL snapshot_%0d @%0d: got req/com/hlt/err/cnt/ins=%h, required %h",
                         s.tag, cyc, obs, s.data);
            end
        end

        if (imem_req && imem_ack) observe(EV_FETCH, imem_addr);
        if (cw_commit)            observe(EV_COMMIT, {instr_count, instruction});
        if (halted && !halted_q)  observe(EV_HALT, 64'd0);
        if (error && !error_q)    observe(EV_ERROR, 64'd0);
        halted_q = halted;
        error_q  = error;

        if (done) begin
            total++;
            if (evq.size() != 0 || snq.size() != 0) begin
                bad++;
                $display("FAIL leftover: got %0d events and %0d snapshots pending, required 0",
                         evq.size(), snq.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

endmodule
